// File: rtl/axi_if.sv
// AXI4 bundle with 32-bit address/data and parameterised ID width.
// The slave modport is the view of an on-chip memory target.
`timescale 1ns/1ps
interface axi_if #(
    parameter int ID_WIDTH = 4
) ();
    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [31:0]         wdata;
    logic [3:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_WIDTH-1:0] rid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_burst_ram_slave.sv
// Single-ported AXI4 burst RAM: one INCR burst (read or write) in service at a time,
// registered read path, per-beat DECERR outside the array, SLVERR on malformed bursts.
`timescale 1ns/1ps
module axi_burst_ram_slave #(
    parameter int          MEM_DEPTH_WORDS = 8192,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          ID_WIDTH        = 4
) (
    input logic  clk,
    input logic  rst_n,
    axi_if.slave s_axi
);
    localparam int IDX_W = $clog2(MEM_DEPTH_WORDS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, W_DATA, W_RESP, R_DATA} state_t;

    state_t              state_q, state_d;
    logic [31:0]         mem [MEM_DEPTH_WORDS];
    logic [ID_WIDTH-1:0] id_q;
    logic [7:0]          len_q, beat_q;
    logic [31:0]         idx_q;
    logic                below_q, slverr_q, decerr_q, wlast_seen_q;
    logic [31:0]         rdata_q;
    logic [1:0]          rresp_q;
    logic                rvalid_q, rlast_q;

    logic                aw_hs, ar_hs, w_hs, r_hs, cur_in_range;
    logic [32:0]         aw_off, ar_off;
    logic [31:0]         aw_idx, ar_idx;
    logic                ar_in_range, ar_bad_fmt;

    function automatic logic [1:0] beat_resp(input logic in_range, input logic slverr);
        return !in_range ? RESP_DECERR : (slverr ? RESP_SLVERR : RESP_OKAY);
    endfunction

    // Bit 32 of the offset is the borrow, i.e. the address lies below BASE_ADDR.
    assign aw_off      = {1'b0, s_axi.awaddr} - {1'b0, BASE_ADDR};
    assign ar_off      = {1'b0, s_axi.araddr} - {1'b0, BASE_ADDR};
    assign aw_idx      = {2'b00, aw_off[31:2]};
    assign ar_idx      = {2'b00, ar_off[31:2]};
    assign ar_in_range = !ar_off[32] && (ar_idx < 32'(MEM_DEPTH_WORDS));
    assign ar_bad_fmt  = (s_axi.arsize != 3'b010) || (s_axi.arburst != 2'b01);
    assign cur_in_range = !below_q && (idx_q < 32'(MEM_DEPTH_WORDS));

    assign aw_hs = (state_q == IDLE) && rst_n && s_axi.awvalid;
    assign ar_hs = (state_q == IDLE) && rst_n && !s_axi.awvalid && s_axi.arvalid;
    assign w_hs  = (state_q == W_DATA) && s_axi.wvalid;
    assign r_hs  = rvalid_q && s_axi.rready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        s_axi.awready = 1'b0;
        s_axi.arready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Readies are gated by rst_n so they drop the instant reset asserts.
                s_axi.awready = rst_n;
                s_axi.arready = rst_n && !s_axi.awvalid;
                if (aw_hs)      state_d = W_DATA;
                else if (ar_hs) state_d = R_DATA;
            end
            W_DATA: begin
                s_axi.wready = 1'b1;
                if (w_hs && (beat_q == len_q)) state_d = W_RESP;
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) state_d = IDLE;
            end
            R_DATA: begin
                if (r_hs && rlast_q) state_d = IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments throughout so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_q         <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            idx_q        <= '0;
            below_q      <= 1'b0;
            slverr_q     <= 1'b0;
            decerr_q     <= 1'b0;
            wlast_seen_q <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
        end else if (aw_hs) begin
            id_q         <= s_axi.awid;
            len_q        <= s_axi.awlen;
            beat_q       <= '0;
            idx_q        <= aw_idx;
            below_q      <= aw_off[32];
            slverr_q     <= (s_axi.awsize != 3'b010) || (s_axi.awburst != 2'b01);
            decerr_q     <= 1'b0;
            wlast_seen_q <= 1'b0;
        end else if (ar_hs) begin
            // Beat 0 is fetched on the handshake edge; idx_q then points at beat 1.
            id_q     <= s_axi.arid;
            len_q    <= s_axi.arlen;
            beat_q   <= '0;
            idx_q    <= ar_idx + 32'd1;
            below_q  <= ar_off[32];
            slverr_q <= ar_bad_fmt;
            decerr_q <= 1'b0;
            rdata_q  <= ar_in_range ? mem[ar_idx[IDX_W-1:0]] : '0;
            rresp_q  <= beat_resp(ar_in_range, ar_bad_fmt);
            rlast_q  <= (s_axi.arlen == 8'd0);
            rvalid_q <= 1'b1;
        end else if (w_hs) begin
            idx_q  <= idx_q + 32'd1;
            beat_q <= beat_q + 8'd1;
            if (!cur_in_range) decerr_q <= 1'b1;
            if (beat_q == len_q) begin
                if (!s_axi.wlast || wlast_seen_q) slverr_q <= 1'b1;
            end else if (s_axi.wlast) begin
                wlast_seen_q <= 1'b1;
            end
        end else if (r_hs) begin
            if (rlast_q) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end else begin
                idx_q   <= idx_q + 32'd1;
                beat_q  <= beat_q + 8'd1;
                rdata_q <= cur_in_range ? mem[idx_q[IDX_W-1:0]] : '0;
                rresp_q <= beat_resp(cur_in_range, slverr_q);
                rlast_q <= (beat_q + 8'd1 == len_q);
            end
        end
    end

    // NOTE: the array has no reset so it maps onto block RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_hs && cur_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi.wstrb[b]) mem[idx_q[IDX_W-1:0]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
            end
        end
    end

    assign s_axi.bid    = id_q;
    assign s_axi.bresp  = decerr_q ? RESP_DECERR : (slverr_q ? RESP_SLVERR : RESP_OKAY);
    assign s_axi.rid    = id_q;
    assign s_axi.rdata  = rdata_q;
    assign s_axi.rresp  = rresp_q;
    assign s_axi.rlast  = rlast_q;
    assign s_axi.rvalid = rvalid_q;
endmodule

// File: tb/tb_axi_burst_ram_slave.sv
// Self-checking bench for axi_burst_ram_slave: table of write/readback bursts plus
// hand-written sequences for backpressure, simultaneous requests and mid-burst reset.
`timescale 1ns/1ps
module tb_axi_burst_ram_slave;
    localparam int DEPTH  = 8192;
    localparam int BUDGET = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_if #(.ID_WIDTH(4)) s ();

    axi_burst_ram_slave #(
        .MEM_DEPTH_WORDS(DEPTH),
        .BASE_ADDR      (32'h0000_0000),
        .ID_WIDTH       (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .s_axi(s)
    );

    typedef struct {
        logic [31:0] addr;
        int          len;
        logic [3:0]  id;
        logic [1:0]  burst;
        logic [31:0] dbase;
        logic [3:0]  strb;
        int          wlast_at;
        logic [1:0]  exp_bresp;
    } wvec_t;

    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rexp_t;

    bexp_t       b_sb[$];
    rexp_t       r_sb[$];
    logic [31:0] model [DEPTH];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic give_up(input string what);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no response within %0d cycles", what, BUDGET);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    task automatic axi_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                             input logic [1:0] burst, input logic [31:0] dbase,
                             input logic [3:0] strb, input int wlast_at,
                             input logic [1:0] exp_bresp, input bit with_ar);
        int    c;
        bexp_t be;
        be.id = id;
        be.resp = exp_bresp;
        b_sb.push_back(be);
        for (int i = 0; i <= len; i++) begin
            int          idx;
            logic [31:0] d;
            idx = int'(addr >> 2) + i;
            d   = dbase + 32'(i);
            if (idx < DEPTH)
                for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = d[8*b +: 8];
        end

        @(negedge clk);
        s.awid = id; s.awaddr = addr; s.awlen = 8'(len); s.awsize = 3'b010;
        s.awburst = burst; s.awvalid = 1'b1;
        if (with_ar) begin
            s.arid = 4'hE; s.araddr = addr; s.arlen = 8'd0; s.arsize = 3'b010;
            s.arburst = 2'b01; s.arvalid = 1'b1;
        end
        #1;
        if (with_ar) begin
            check("simul_awready", 32'(s.awready), 32'd1);
            check("simul_arready", 32'(s.arready), 32'd0);
        end
        c = 0;
        while (!s.awready) begin
            if (++c > BUDGET) give_up("aw_handshake");
            @(negedge clk); #1;
        end
        @(negedge clk);
        s.awvalid = 1'b0;
        s.arvalid = 1'b0;

        for (int i = 0; i <= len; i++) begin
            s.wdata = dbase + 32'(i); s.wstrb = strb; s.wlast = (i == wlast_at); s.wvalid = 1'b1;
            #1;
            c = 0;
            while (!s.wready) begin
                if (++c > BUDGET) give_up("w_beat");
                @(negedge clk); #1;
            end
            @(negedge clk);
        end
        s.wvalid = 1'b0;
        s.wlast  = 1'b0;
        #1;
        check("wready_after_last", 32'(s.wready), 32'd0);

        s.bready = 1'b1;
        c = 0;
        while (!s.bvalid) begin
            if (++c > BUDGET) give_up("b_response");
            @(negedge clk); #1;
        end
        be = b_sb.pop_front();
        check("bresp", 32'(s.bresp), 32'(be.resp));
        check("bid", 32'(s.bid), 32'(be.id));
        @(negedge clk);
        s.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input logic [3:0] id,
                            input logic [1:0] burst, input bit rr_pat[$]);
        int    c, p, got;
        rexp_t e;
        for (int i = 0; i <= len; i++) begin
            int idx;
            idx    = int'(addr >> 2) + i;
            e.data = (idx < DEPTH) ? model[idx] : 32'h0;
            e.resp = (idx >= DEPTH) ? 2'b11 : ((burst != 2'b01) ? 2'b10 : 2'b00);
            e.last = (i == len);
            e.id   = id;
            r_sb.push_back(e);
        end

        @(negedge clk);
        s.arid = id; s.araddr = addr; s.arlen = 8'(len); s.arsize = 3'b010;
        s.arburst = burst; s.arvalid = 1'b1;
        #1;
        c = 0;
        while (!s.arready) begin
            if (++c > BUDGET) give_up("ar_handshake");
            @(negedge clk); #1;
        end
        @(negedge clk);
        s.arvalid = 1'b0;

        p = 0;
        got = 0;
        s.rready = (p < rr_pat.size()) ? rr_pat[p] : 1'b1;
        #1;
        check("r_first_beat_latency", 32'(s.rvalid), 32'd1);
        c = 0;
        while (got <= len) begin
            if (s.rvalid) begin
                e = r_sb[0];
                check($sformatf("rdata[%0d]", got), s.rdata, e.data);
                check($sformatf("rresp[%0d]", got), 32'(s.rresp), 32'(e.resp));
                check($sformatf("rlast[%0d]", got), 32'(s.rlast), 32'(e.last));
                check($sformatf("rid[%0d]", got), 32'(s.rid), 32'(e.id));
                if (s.rready) begin
                    void'(r_sb.pop_front());
                    got++;
                end
            end else if (++c > BUDGET) begin
                give_up("r_beat");
            end
            @(negedge clk);
            p++;
            s.rready = (p < rr_pat.size()) ? rr_pat[p] : 1'b1;
            #1;
        end
        check("rvalid_after_last", 32'(s.rvalid), 32'd0);
        s.rready = 1'b0;
    endtask

    initial begin
        bit    pat_all[$];
        bit    pat_bp[$];
        wvec_t vec[7];
        int    c;

        s.awid = '0; s.awaddr = '0; s.awlen = '0; s.awsize = '0; s.awburst = '0; s.awvalid = 1'b0;
        s.wdata = '0; s.wstrb = '0; s.wlast = 1'b0; s.wvalid = 1'b0; s.bready = 1'b0;
        s.arid = '0; s.araddr = '0; s.arlen = '0; s.arsize = '0; s.arburst = '0; s.arvalid = 1'b0;
        s.rready = 1'b0;
        pat_bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        //          addr          len  id    burst  dbase          strb     wlast  bresp
        vec[0] = '{32'h0000_0100, 127, 4'h3, 2'b01, 32'hA000_0000, 4'hF,    127,   2'b00};
        vec[1] = '{32'h0000_1000, 3,   4'h5, 2'b01, 32'hB000_0000, 4'hF,    -1,    2'b10};
        vec[2] = '{32'h0000_1100, 3,   4'h6, 2'b01, 32'hB100_0000, 4'hF,    1,     2'b10};
        vec[3] = '{32'h0000_1200, 1,   4'h7, 2'b00, 32'hB200_0000, 4'hF,    1,     2'b10};
        vec[4] = '{32'h0000_7FF8, 3,   4'h9, 2'b01, 32'hD000_0000, 4'hF,    3,     2'b11};
        vec[5] = '{32'h0000_0200, 0,   4'h1, 2'b01, 32'h1122_3344, 4'hF,    0,     2'b00};
        vec[6] = '{32'h0000_0200, 0,   4'h2, 2'b01, 32'hAABB_CCDD, 4'b0101, 0,     2'b00};

        repeat (3) @(negedge clk);
        #1;
        check("rst_awready", 32'(s.awready), 32'd0);
        check("rst_arready", 32'(s.arready), 32'd0);
        check("rst_wready",  32'(s.wready),  32'd0);
        check("rst_bvalid",  32'(s.bvalid),  32'd0);
        check("rst_rvalid",  32'(s.rvalid),  32'd0);
        check("rst_rlast",   32'(s.rlast),   32'd0);
        check("rst_bresp",   32'(s.bresp),   32'd0);
        check("rst_rresp",   32'(s.rresp),   32'd0);
        check("rst_rdata",   s.rdata,        32'd0);
        check("rst_ids",     32'({s.bid, s.rid}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_awready", 32'(s.awready), 32'd1);
        check("idle_arready", 32'(s.arready), 32'd1);

        for (int v = 0; v < 7; v++) begin
            axi_write(vec[v].addr, vec[v].len, vec[v].id, vec[v].burst, vec[v].dbase,
                      vec[v].strb, vec[v].wlast_at, vec[v].exp_bresp, 1'b0);
            axi_read(vec[v].addr, vec[v].len, vec[v].id, 2'b01, pat_all);
        end

        axi_read(32'h0000_0100, 3, 4'hA, 2'b01, pat_bp);
        axi_read(32'h0000_1000, 1, 4'hB, 2'b00, pat_all);

        axi_write(32'h0000_0400, 1, 4'hC, 2'b01, 32'hE000_0000, 4'hF, 1, 2'b00, 1'b1);
        axi_read(32'h0000_0400, 1, 4'hD, 2'b01, pat_all);

        // Reset in the middle of a 128-beat write, while beat 10 is on the bus.
        @(negedge clk);
        s.awid = 4'h4; s.awaddr = 32'h0000_2000; s.awlen = 8'd127; s.awsize = 3'b010;
        s.awburst = 2'b01; s.awvalid = 1'b1;
        #1;
        c = 0;
        while (!s.awready) begin
            if (++c > BUDGET) give_up("rst_aw_handshake");
            @(negedge clk); #1;
        end
        @(negedge clk);
        s.awvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s.wdata = 32'hC000_0000 + 32'(i); s.wstrb = 4'hF; s.wlast = 1'b0; s.wvalid = 1'b1;
            model[(32'h2000 >> 2) + i] = 32'hC000_0000 + 32'(i);
            #1;
            c = 0;
            while (!s.wready) begin
                if (++c > BUDGET) give_up("rst_w_beat");
                @(negedge clk); #1;
            end
            @(negedge clk);
        end
        s.wdata = 32'hC000_000A;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_wready",  32'(s.wready),  32'd0);
        check("midrst_awready", 32'(s.awready), 32'd0);
        check("midrst_arready", 32'(s.arready), 32'd0);
        check("midrst_bvalid",  32'(s.bvalid),  32'd0);
        check("midrst_rvalid",  32'(s.rvalid),  32'd0);
        @(negedge clk);
        s.wvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_idle_awready", 32'(s.awready), 32'd1);
        check("midrst_idle_wready",  32'(s.wready),  32'd0);
        axi_read(32'h0000_2000, 9, 4'h4, 2'b01, pat_all);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
